// File: rtl/bcd_sub_seq.sv
// Multi-digit packed-BCD subtract sequencer: diff = |a - b|, neg = (a < b), one digit per clock, LSD first.
// Optional input-nibble validity check (CHECK state, err output) is compiled in by defining BCD_SUB_SEQ_ERR_EN.

module bcd_sub_seq #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SUB   = 3'd2,
    NEG   = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    r_q, r_d;
  logic            borrow_q, borrow_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;

  logic [4:0]      t_c;
  logic [3:0]      digit_c;
  logic            bout_c;
  logic            last_c;
  logic [W-1:0]    r_step_c;

`ifdef BCD_SUB_SEQ_ERR_EN
  logic            bad_c;

  function automatic logic has_bad_nibble(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb bad_c = has_bad_nibble(a_q) | has_bad_nibble(b_q);
`endif

  // Single-digit subtract-with-borrow step shared by the SUB and NEG passes
  always_comb begin
    t_c      = 5'({1'b0, a_q[3:0]}) - 5'({1'b0, b_q[3:0]}) - 5'(borrow_q);
    bout_c   = t_c[4];
    digit_c  = bout_c ? 4'(t_c + 5'd10) : t_c[3:0];
    r_step_c = W'({digit_c, r_q} >> 4);
    last_c   = (cnt_q == CW'(DIGITS - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef BCD_SUB_SEQ_ERR_EN
          state_d = CHECK;
`else
          state_d = SUB;
`endif
        end
      end
      CHECK: begin
`ifdef BCD_SUB_SEQ_ERR_EN
        state_d = bad_c ? DONE : SUB;
`else
        state_d = SUB;
`endif
      end
      SUB: begin
        if (last_c) state_d = bout_c ? NEG : DONE;
      end
      NEG: begin
        if (last_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next-values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    neg_d    = neg_q;
    err_d    = err_q;
    busy_d   = (state_q != IDLE);
    done_d   = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          r_d      = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          err_d    = 1'b0;
        end
      end
      CHECK: begin
        cnt_d    = '0;
        borrow_d = 1'b0;
`ifdef BCD_SUB_SEQ_ERR_EN
        if (bad_c) begin
          diff_d = '0;
          neg_d  = 1'b0;
          err_d  = 1'b1;
        end
`endif
      end
      SUB: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        r_d      = r_step_c;
        borrow_d = bout_c;
        cnt_d    = cnt_q + CW'(1);
        if (last_c) begin
          cnt_d = '0;
          if (bout_c) begin
            // Raw result is the 10's complement of |a-b|; negate it as 0 - raw
            a_d      = '0;
            b_d      = r_step_c;
            borrow_d = 1'b0;
          end else begin
            diff_d = r_step_c;
            neg_d  = 1'b0;
          end
        end
      end
      NEG: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        r_d      = r_step_c;
        borrow_d = bout_c;
        cnt_d    = cnt_q + CW'(1);
        if (last_c) begin
          cnt_d  = '0;
          diff_d = r_step_c;
          neg_d  = 1'b1;
        end
      end
      default: ;
    endcase
`ifndef BCD_SUB_SEQ_ERR_EN
    err_d = 1'b0;
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign neg  = neg_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Self-checking bench for bcd_sub_seq (DIGITS=4): decimal-arithmetic model plus literal cases.
// Follows BCD_SUB_SEQ_ERR_EN the same way the design does.

module tb_bcd_sub_seq;

  localparam int D = 4;
  localparam int W = 4 * D;
`ifdef BCD_SUB_SEQ_ERR_EN
  localparam int FEAT = 1;
`else
  localparam int FEAT = 0;
`endif
  localparam int LAT_GE  = FEAT + 1 + D;
  localparam int LAT_LT  = FEAT + 1 + 2 * D;

  typedef struct packed {
    logic [W-1:0] d;
    logic         n;
    logic         e;
    logic [7:0]   l;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, neg, err;
  logic [W-1:0] diff;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic m_active = 1'b0;
  int   m_t0 = 0;
  res_t m_res = '0;

  bcd_sub_seq #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in),
    .busy(busy), .done(done), .diff(diff), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int acc = 0;
    for (int i = D - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return acc;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] r = '0;
    int v = x;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic bad_bcd(input logic [W-1:0] v);
    logic bad = 1'b0;
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Reference result from plain decimal arithmetic
  function automatic res_t model_eval(input logic [W-1:0] av, input logic [W-1:0] bv);
    res_t r;
    int ai, bi;
    if (FEAT == 1 && (bad_bcd(av) || bad_bcd(bv))) begin
      r.d = '0; r.n = 1'b0; r.e = 1'b1; r.l = 8'd2;
    end else begin
      ai = bcd2int(av);
      bi = bcd2int(bv);
      r.e = 1'b0;
      if (ai >= bi) begin
        r.d = int2bcd(ai - bi); r.n = 1'b0; r.l = 8'(LAT_GE);
      end else begin
        r.d = int2bcd(bi - ai); r.n = 1'b1; r.l = 8'(LAT_LT);
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(9, 0));
    if (FEAT == 1 && ($urandom % 10) == 0)
      v[4*int'($urandom % D) +: 4] = 4'($urandom_range(15, 10));
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: an op is accepted on an edge when start is high and the previous op has fully retired
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
    end else if (start && (!m_active || (cyc + 1) > m_t0 + int'(m_res.l))) begin
      m_active <= 1'b1;
      m_t0     <= cyc + 1;
      m_res    <= model_eval(a_in, b_in);
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("busy", 32'(busy),
        32'(m_active && cyc >= m_t0 + 1 && cyc <= m_t0 + int'(m_res.l)));
    chk("done", 32'(done), 32'(m_active && cyc == m_t0 + int'(m_res.l)));
    if (m_active && cyc == m_t0 + int'(m_res.l)) begin
      chk("diff", 32'(diff), 32'(m_res.d));
      chk("neg",  32'(neg),  32'(m_res.n));
      chk("err",  32'(err),  32'(m_res.e));
    end
  end

  // Called one window after an op's start edge; returns windows until done (-1 on timeout)
  task automatic wait_done(input bit noise, output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (noise) begin
        start = (($urandom % 3) == 0);
        a_in  = W'($urandom);
        b_in  = W'($urandom);
      end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noise,
                       output int lat);
    a_in = av; b_in = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(noise, lat);
    start = 1'b0;
  endtask

  task automatic lit_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic en, input int el);
    int lat;
    do_op(av, bv, 1'b0, lat);
    chk({nm, "_lat"},  32'(lat),  32'(el));
    chk({nm, "_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_neg"},  32'(neg),  32'(en));
    chk({nm, "_err"},  32'(err),  32'd0);
  endtask

  initial begin
    int   lat;
    res_t r;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_neg",  32'(neg),  32'd0);
    chk("rst_err",  32'(err),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model with hand-computed results
    r = model_eval(16'h0753, 16'h0246);
    chk("model_ge_diff", 32'(r.d), 32'h0507);
    chk("model_ge_lat",  32'(r.l), 32'(5 + FEAT));
    r = model_eval(16'h0000, 16'h0001);
    chk("model_lt_diff", 32'(r.d), 32'h0001);
    chk("model_lt_neg",  32'(r.n), 32'd1);
    chk("model_lt_lat",  32'(r.l), 32'(9 + FEAT));

    lit_op("ge",   16'h0753, 16'h0246, 16'h0507, 1'b0, 5 + FEAT);
    lit_op("lt",   16'h0246, 16'h0753, 16'h0507, 1'b1, 9 + FEAT);
    lit_op("z_m1", 16'h0000, 16'h0001, 16'h0001, 1'b1, 9 + FEAT);
    lit_op("max",  16'h9999, 16'h0001, 16'h9998, 1'b0, 5 + FEAT);
    lit_op("eq",   16'h1234, 16'h1234, 16'h0000, 1'b0, 5 + FEAT);
`ifdef BCD_SUB_SEQ_ERR_EN
    do_op(16'h00A3, 16'h0001, 1'b0, lat);
    chk("bad_lat",  32'(lat),  32'd2);
    chk("bad_err",  32'(err),  32'd1);
    chk("bad_diff", 32'(diff), 32'd0);
    chk("bad_neg",  32'(neg),  32'd0);
    lit_op("clr_err", 16'h0753, 16'h0246, 16'h0507, 1'b0, 5 + FEAT);
`endif

    // start held high: second op is taken only after the first retires
    a_in = 16'h0753; b_in = 16'h0246; start = 1'b1;
    @(posedge clk); #1;
    a_in = 16'h0100; b_in = 16'h0050;
    wait_done(1'b0, lat);
    chk("hold1_lat",  32'(lat),  32'(5 + FEAT));
    chk("hold1_diff", 32'(diff), 32'h0507);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, lat);
    chk("hold2_lat",  32'(lat),  32'(5 + FEAT));
    chk("hold2_diff", 32'(diff), 32'h0050);

    // Make the held result nonzero, then abort an op mid-SUB with reset
    lit_op("pre_rst", 16'h0246, 16'h0753, 16'h0507, 1'b1, 9 + FEAT);
    a_in = 16'h9999; b_in = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_neg",  32'(neg),  32'd0);
    chk("arst_err",  32'(err),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    lit_op("post_rst", 16'h0500, 16'h0250, 16'h0250, 1'b0, 5 + FEAT);

    // Randomized ops with start noise while busy
    for (int i = 0; i < 150; i++) begin
      ra = rand_bcd();
      rb = (($urandom % 8) == 0) ? ra : rand_bcd();
      do_op(ra, rb, 1'b1, lat);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_sub_seq.md
Name: bcd_sub_seq

Overview:
- Multi-digit packed-BCD subtract sequencer: computes |a - b| and a sign flag.
- Drives a single-digit BCD subtract-with-borrow step, one digit per clock, LSD first.
- A second negate pass turns a 10's-complement raw result into a magnitude.
- Sits between a register/bus front end and the BCD arithmetic datapath; start/busy/done handshake.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>= 1); operand width = 4*DIGITS.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  4*DIGITS  minuend, packed BCD; captured with start
- b  input  4*DIGITS  subtrahend, packed BCD; captured with start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when result is valid
- diff  output  4*DIGITS  magnitude |a-b|, packed BCD
- neg  output  1  1 when a < b
- err  output  1  1 when an input nibble > 9 (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy=0, done=0, diff=0, neg=0, err=0; internal operand, borrow and digit counter regs = 0.
- FSM states: IDLE, CHECK, SUB, NEG, DONE.
- IDLE: when start=1 at the edge, capture a and b into shift regs, clear borrow and counter, clear err.
  - With the optional feature compiled in, go to CHECK; otherwise go to SUB.
  - start=0 keeps the block in IDLE. diff, neg and err hold the previous result.
- CHECK (1 cycle):
  - If any nibble of a or b > 9: diff=0, neg=0, err=1, go to DONE.
  - Otherwise go to SUB.
- Digit step, used by both SUB and NEG: t = x - y - bin, computed in 5-bit signed.
  - If t < 0: digit = t + 10 and bout = 1. Otherwise digit = t and bout = 0.
  - Result digit shifts into the MSD of the result reg; operands shift right by 4.
- SUB (exactly DIGITS cycles): x = a digit, y = b digit.
  - After the last digit: if final borrow = 1, load x = 0, y = raw result, borrow = 0, and go to NEG. Otherwise diff = raw result, neg = 0, go to DONE.
- NEG (exactly DIGITS cycles): computes 0 - raw. Then diff = result, neg = 1, go to DONE.
- DONE (1 cycle): done=1, busy=1, then go to IDLE. start is ignored in DONE.
- Latency from the start-sampling edge to done high (feature on): 2+DIGITS cycles when a >= b, 2+2*DIGITS when a < b. With the feature off, subtract 1.
- start while busy: ignored; no queuing, no effect on the operation in flight.
- a == b: diff=0, neg=0, no NEG pass.
- Result is never -0: neg=1 only if the magnitude is nonzero.
- diff, neg and err update only on entry to DONE.
- rst_n low mid-operation: immediate return to reset values; the operation is abandoned and no done is issued.
- Counter wraps: the digit counter runs 0..DIGITS-1 and is cleared on each SUB/NEG entry.

Optional Feature:
- Macro: BCD_SUB_SEQ_ERR_EN.
- Defined: CHECK state exists, invalid nibbles produce err=1 and diff=0, and latency is as above.
- Undefined: no CHECK state; IDLE goes straight to SUB and latency is 1 cycle shorter.
  - err is tied to 0.
  - Invalid nibbles are processed arithmetically with no guarantee on diff.

Test Plan (DIGITS=4, feature on):
- a=0x0753, b=0x0246, start pulse -> done 6 cycles later; diff=0x0507, neg=0, err=0; busy high cycles 1..6.
- a=0x0246, b=0x0753 -> done after 10 cycles; diff=0x0507, neg=1.
- a=0x0000, b=0x0001 -> diff=0x0001, neg=1. Then a=0x9999, b=0x0001 -> diff=0x9998, neg=0. Then a=b=0x1234 -> diff=0x0000, neg=0.
- a=0x00A3, b=0x0001 -> done after 2 cycles; err=1, diff=0, neg=0. Next valid op clears err.
- start held high through an operation with new a/b -> only the first captured op completes; the second start is accepted only after return to IDLE.
- rst_n pulsed low during SUB -> outputs 0 immediately, no done pulse. A following op 0x0500-0x0250 gives diff=0x0250, neg=0.
- Rerun case 1 with the macro undefined -> done after 5 cycles, err stays 0.
